// File: rtl/key_matrix_scanner_if.sv
// Key event handshake: show-ahead head of the event FIFO, popped on valid && ready.
interface key_matrix_scanner_if #(
  parameter int unsigned KW = 4
);
  logic          keyValid;
  logic          keyReady;
  logic [KW-1:0] keyCode;
  logic          keyPress;

  // Scanner side: presents the head event.
  modport master (
    output keyValid,
    output keyCode,
    output keyPress,
    input  keyReady
  );

  // Consumer side: accepts the head event.
  modport slave (
    input  keyValid,
    input  keyCode,
    input  keyPress,
    output keyReady
  );
endinterface

// File: rtl/key_matrix_scanner.sv
// Key matrix scanner: strobes one column at a time, samples the rows after a
// settle delay, debounces every key across frames and queues press/release
// events in a 4-deep show-ahead FIFO.
module key_matrix_scanner #(
  parameter int unsigned NCOLS    = 4,
  parameter int unsigned NROWS    = 4,
  parameter int unsigned SETTLE   = 3,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NROWS-1:0]   rowIn,
  output logic [NCOLS-1:0]   colOut,
  output logic               overflow,
  key_matrix_scanner_if.master key
);

  localparam int unsigned CW     = (NCOLS > 1) ? $clog2(NCOLS) : 1;
  localparam int unsigned RW     = (NROWS > 1) ? $clog2(NROWS) : 1;
  localparam int unsigned KW     = CW + RW;
  localparam int unsigned NKEYS  = 1 << KW;
  localparam int unsigned SPW    = 1 << RW;
  localparam int unsigned SW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned DW     = $clog2(DEBOUNCE + 1);
  localparam int unsigned FDEPTH = 4;
  localparam int unsigned PW     = 2;
  localparam int unsigned CNTW   = 3;

  typedef enum logic {
    S_DRIVE = 1'b0,
    S_EMIT  = 1'b1
  } state_t;

  typedef struct packed {
    logic [KW-1:0] code;
    logic          press;
  } event_t;

  // Scan and debounce state
  state_t                   state_q;
  logic [CW-1:0]            col_q;
  logic [SW-1:0]            settle_q;
  logic [RW-1:0]            row_q;
  logic [SPW-1:0]           sample_q;
  logic [NKEYS-1:0]         stable_q;
  logic [NKEYS-1:0][DW-1:0] db_q;
  logic [NCOLS-1:0]         colOut_q;

  // Event FIFO state
  event_t [FDEPTH-1:0]      mem_q;
  logic [PW-1:0]            rd_q, rd_d;
  logic [PW-1:0]            wr_q, wr_d;
  logic [CNTW-1:0]          count_q, count_d;
  logic                     valid_q, valid_d;
  event_t                   head_q, head_d;
  logic                     ovf_q;

  // Per-row debounce decision for the key under the EMIT pointer
  logic [KW-1:0]            key_c;
  logic                     diff_c;
  logic                     flip_c;
  logic                     push_c;
  event_t                   push_ev_c;
  logic [CW-1:0]            col_next_c;

  // FIFO control
  logic                     pop_c;
  logic                     full_c;
  logic                     acc_c;
  logic                     drop_c;

  // Evaluate the current key against its sampled level and pick the next column.
  always_comb begin
    key_c      = {col_q, row_q};
    diff_c     = sample_q[row_q] ^ stable_q[key_c];
    flip_c     = diff_c && (db_q[key_c] == DW'(DEBOUNCE - 1));
    push_c     = (state_q == S_EMIT) && flip_c;
    push_ev_c  = '{code: key_c, press: ~stable_q[key_c]};
    col_next_c = (col_q == CW'(NCOLS - 1)) ? '0 : col_q + CW'(1);
  end

  // Scan FSM: settle-count a driven column, then walk its rows one per clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_DRIVE;
      col_q    <= '0;
      settle_q <= '0;
      row_q    <= '0;
      sample_q <= '0;
      stable_q <= '0;
      db_q     <= '0;
      colOut_q <= NCOLS'(1);
    end else begin
      case (state_q)
        S_DRIVE: begin
          if (enable) begin
            if (settle_q == SW'(SETTLE - 1)) begin
              sample_q <= SPW'(rowIn);
              settle_q <= '0;
              row_q    <= '0;
              state_q  <= S_EMIT;
            end else begin
              settle_q <= settle_q + SW'(1);
            end
          end
        end
        S_EMIT: begin
          if (!diff_c) begin
            db_q[key_c] <= '0;
          end else if (flip_c) begin
            stable_q[key_c] <= ~stable_q[key_c];
            db_q[key_c]     <= '0;
          end else begin
            db_q[key_c] <= db_q[key_c] + DW'(1);
          end
          if (row_q == RW'(NROWS - 1)) begin
            col_q    <= col_next_c;
            colOut_q <= NCOLS'(1) << col_next_c;
            state_q  <= S_DRIVE;
          end else begin
            row_q <= row_q + RW'(1);
          end
        end
        default: state_q <= S_DRIVE;
      endcase
    end
  end

  // FIFO next state; the head register bypasses a push that lands on the new read slot.
  always_comb begin
    pop_c   = valid_q && key.keyReady;
    full_c  = (count_q == CNTW'(FDEPTH));
    acc_c   = push_c && (!full_c || pop_c);
    drop_c  = push_c && full_c && !pop_c;
    rd_d    = pop_c ? rd_q + PW'(1) : rd_q;
    wr_d    = acc_c ? wr_q + PW'(1) : wr_q;
    count_d = count_q;
    case ({acc_c, pop_c})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != '0);
    head_d  = (acc_c && (rd_d == wr_q)) ? push_ev_c : mem_q[rd_d];
  end

  // FIFO storage, pointers, registered head outputs and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (acc_c) begin
        mem_q[wr_q] <= push_ev_c;
      end
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      if (drop_c) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign colOut       = colOut_q;
  assign overflow     = ovf_q;
  assign key.keyValid = valid_q;
  assign key.keyCode  = head_q.code;
  assign key.keyPress = head_q.press;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Bench for key_matrix_scanner: enable-gating vector table, directed key
// scenarios and random key activity, all checked against a frame-level model.
module tb_key_matrix_scanner;

  localparam int NC = 4;
  localparam int NR = 4;
  localparam int ST = 3;
  localparam int DB = 4;
  localparam int CP = ST + NR;   // clocks per column with enable held
  localparam int FP = NC * CP;   // clocks per frame

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [NR-1:0] rowIn;
  logic [NC-1:0] colOut;
  logic          overflow;

  key_matrix_scanner_if #(.KW(4)) kif ();

  key_matrix_scanner #(
    .NCOLS(NC), .NROWS(NR), .SETTLE(ST), .DEBOUNCE(DB)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .rowIn(rowIn),
    .colOut(colOut), .overflow(overflow), .key(kif)
  );

  always #5 clk = ~clk;

  typedef struct { int t; int code; bit press; } pend_t;
  typedef struct { int code; bit press; } ev_t;
  typedef struct { bit en; logic [NC-1:0] col; } vec_t;

  // Physical key matrix: keys[c][r] = 1 means closed
  bit    keys [NC][NR];
  // Reference model
  bit    mst  [NC*NR];
  int    mdb  [NC*NR];
  pend_t pend [$];
  ev_t   mfifo[$];
  bit    movf;
  int    e;
  // Events actually popped from the DUT
  ev_t   dut_log[$];

  int    rdy_mode;
  bit    rand_keys;
  int    checks = 0;
  int    errors = 0;
  vec_t  tbl[18];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t (edge %0d)", name, act, exp, $time, e);
    end
  endtask

  function automatic logic [NR-1:0] rows_for(input logic [NC-1:0] co);
    logic [NR-1:0] r;
    r = '0;
    for (int c = 0; c < NC; c++)
      for (int rr = 0; rr < NR; rr++)
        if (co[c] && keys[c][rr]) r[rr] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NC*NR; k++) begin
      mst[k] = 1'b0;
      mdb[k] = 0;
    end
    pend.delete();
    mfifo.delete();
    dut_log.delete();
    movf = 1'b0;
    e = 0;
  endtask

  // Assert reset right now (caller sits mid-cycle), check async values, release at a negedge.
  task automatic do_reset();
    reset = 1'b0;
    enable = 1'b1;
    rowIn = '0;
    #1;
    chk("reset_colOut", int'(colOut), 1);
    chk("reset_keyValid", int'(kif.keyValid), 0);
    chk("reset_keyCode", int'(kif.keyCode), 0);
    chk("reset_keyPress", int'(kif.keyPress), 0);
    chk("reset_overflow", int'(overflow), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // One clock with enable=1; model advances by frame rules and scheduled pushes.
  task automatic step();
    bit    rdy;
    bit    pop;
    int    c;
    int    k;
    pend_t p;
    if (rand_keys && ($urandom_range(0, 7) == 0)) begin
      k = $urandom_range(0, NC*NR-1);
      keys[k/NR][k%NR] = ~keys[k/NR][k%NR];
    end
    case (rdy_mode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      default: rdy = 1'($urandom_range(0, 1));
    endcase
    kif.keyReady = rdy;
    enable = 1'b1;
    rowIn = rows_for(colOut);
    pop = (mfifo.size() > 0) && rdy;
    if (kif.keyValid && rdy) dut_log.push_back('{int'(kif.keyCode), kif.keyPress});
    @(posedge clk);
    e++;
    if (pop) void'(mfifo.pop_front());
    if (pend.size() > 0 && pend[0].t == e) begin
      p = pend.pop_front();
      if (mfifo.size() >= 4) movf = 1'b1;
      else mfifo.push_back('{p.code, p.press});
    end
    if (e % CP == ST) begin
      c = (e / CP) % NC;
      for (int r = 0; r < NR; r++) begin
        k = c * NR + r;
        if (keys[c][r] == mst[k]) mdb[k] = 0;
        else if (mdb[k] == DB - 1) begin
          mst[k] = ~mst[k];
          mdb[k] = 0;
          pend.push_back('{e + 1 + r, k, mst[k]});
        end else mdb[k]++;
      end
    end
    #1;
    chk("colOut", int'(colOut), 1 << ((e / CP) % NC));
    chk("keyValid", int'(kif.keyValid), int'(mfifo.size() > 0));
    if (mfifo.size() > 0) begin
      chk("keyCode", int'(kif.keyCode), mfifo[0].code);
      chk("keyPress", int'(kif.keyPress), int'(mfifo[0].press));
    end
    chk("overflow", int'(overflow), int'(movf));
    @(negedge clk);
  endtask

  task automatic run_frames(input int n);
    repeat (n * FP) step();
  endtask

  task automatic clear_keys();
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++) keys[c][r] = 1'b0;
  endtask

  initial begin
    tbl = '{
      '{1'b1, 4'b0001}, '{1'b0, 4'b0001}, '{1'b0, 4'b0001}, '{1'b1, 4'b0001},
      '{1'b1, 4'b0001}, '{1'b0, 4'b0001}, '{1'b0, 4'b0001}, '{1'b0, 4'b0001},
      '{1'b0, 4'b0010}, '{1'b0, 4'b0010}, '{1'b1, 4'b0010}, '{1'b1, 4'b0010},
      '{1'b0, 4'b0010}, '{1'b1, 4'b0010}, '{1'b1, 4'b0010}, '{1'b1, 4'b0010},
      '{1'b1, 4'b0010}, '{1'b0, 4'b0100}
    };
    reset = 1'b0;
    enable = 1'b1;
    rowIn = '0;
    kif.keyReady = 1'b1;
    rdy_mode = 1;
    rand_keys = 1'b0;
    clear_keys();
    model_reset();
    @(negedge clk);

    // Enable gating: DRIVE freezes without ticks, EMIT runs regardless.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      enable = tbl[i].en;
      rowIn = '0;
      kif.keyReady = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("gate_colOut[%0d]", i), int'(colOut), int'(tbl[i].col));
      chk($sformatf("gate_keyValid[%0d]", i), int'(kif.keyValid), 0);
      @(negedge clk);
    end

    // Press and release of col 2 / row 1.
    do_reset();
    rdy_mode = 1;
    keys[2][1] = 1'b1;
    run_frames(8);
    chk("press_count", dut_log.size(), 1);
    if (dut_log.size() > 0) begin
      chk("press_code", dut_log[0].code, 9);
      chk("press_type", int'(dut_log[0].press), 1);
    end
    dut_log.delete();
    keys[2][1] = 1'b0;
    run_frames(6);
    chk("release_count", dut_log.size(), 1);
    if (dut_log.size() > 0) begin
      chk("release_code", dut_log[0].code, 9);
      chk("release_type", int'(dut_log[0].press), 0);
    end

    // Bounce rejection: 3 closed, 1 open, 3 closed frames.
    do_reset();
    keys[0][0] = 1'b1;
    run_frames(3);
    keys[0][0] = 1'b0;
    run_frames(1);
    keys[0][0] = 1'b1;
    run_frames(3);
    chk("bounce_events", dut_log.size(), 0);
    clear_keys();

    // Overflow then drain.
    do_reset();
    rdy_mode = 0;
    for (int r = 0; r < NR; r++) keys[0][r] = 1'b1;
    keys[1][0] = 1'b1;
    run_frames(4);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_full_valid", int'(kif.keyValid), 1);
    rdy_mode = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_code[%0d]", i), int'(kif.keyCode), i);
      chk($sformatf("drain_press[%0d]", i), int'(kif.keyPress), 1);
      step();
    end
    chk("drain_empty", int'(kif.keyValid), 0);
    chk("drain_ovf_sticky", int'(overflow), 1);
    run_frames(1);
    chk("drain_no_more", dut_log.size(), 4);
    clear_keys();

    // Reset in the middle of EMIT with a debounced key held.
    do_reset();
    keys[1][2] = 1'b1;
    run_frames(5);
    chk("pre_reset_press", dut_log.size(), 1);
    for (int i = 0; i < FP && (e % FP) != 11; i++) step();
    chk("mid_emit_reached", e % FP, 11);
    do_reset();
    run_frames(5);
    chk("rereport_count", dut_log.size(), 1);
    if (dut_log.size() > 0) begin
      chk("rereport_code", dut_log[0].code, 6);
      chk("rereport_type", int'(dut_log[0].press), 1);
    end
    clear_keys();

    // Random key activity with random backpressure.
    do_reset();
    rdy_mode = 2;
    rand_keys = 1'b1;
    run_frames(40);
    rand_keys = 1'b0;
    rdy_mode = 1;
    run_frames(6);
    chk("random_final_empty", int'(kif.keyValid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
